vector_uop_sequencer: RTL and testbench
=======================================

Name: vector_uop_sequencer

Overview:
- Registered vector front-end stage between fetch/decode and the vector lanes.
- Decodes scalar and vector (OP_V, OP_VL, OP_VS) instructions and holds architectural vl/vtype state, updated by vsetvli.
- Splits each vector arithmetic, load or store instruction into ceil(vl/NUM_LANES) micro-op beats on a valid/ready interface.
- Scalar instructions pass through as single-beat uops.

Parameters:
- DATA_WIDTH, 32, instruction and rs1 data width.
- VLEN, 128, vector register length in bits; power of two, at least 64.
- NUM_LANES, 4, elements consumed per uop beat; power of two.
- VL_W, $clog2(VLEN/8)+1, width of vl and beat counters (derived).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_in  input  DATA_WIDTH  instruction word
- instr_valid_in  input  1  instruction offered
- instr_ready_o  output  1  instruction accepted when valid&&ready
- rs1_data_in  input  DATA_WIDTH  rs1 value (AVL for vsetvli), sampled with the instruction
- uop_valid_o  output  1  uop presented
- uop_ready_in  input  1  downstream accepts uop
- uop_is_vector_o  output  1  vector uop (0 = scalar passthrough)
- uop_is_vset_o  output  1  vsetvli result uop
- uop_instr_o  output  DATA_WIDTH  originating instruction
- uop_valu_op_o  output  4  vector ALU op
- uop_vmem_read_o  output  1  vector load beat
- uop_vmem_write_o  output  1  vector store beat
- uop_sew_o  output  2  element width: 00=8, 01=16, 10=32, 11=64
- uop_mask_en_o  output  1  instr[25]
- uop_beat_o  output  VL_W  beat index, 0-based
- uop_last_o  output  1  final beat of the instruction
- uop_vl_o  output  VL_W  current vl; new vl for vset uops
- vl_o  output  VL_W  architectural vl
- vtype_sew_o  output  2  architectural vsew
- vtype_vill_o  output  1  vtype illegal
- illegal_o  output  1  one-cycle pulse: accepted vector op dropped as illegal

Behaviour:
- Reset (async, rst_n=0):
  - All uop_* outputs 0; uop_valid_o=0; illegal_o=0.
  - vl_o=0, vtype_sew_o=00, vtype_vill_o=1.
  - An in-flight multi-beat sequence is discarded.
- Handshake:
  - instr_ready_o = !uop_valid_o || (uop_ready_in && uop_last_o).
  - Acceptance at edge N presents beat 0 from cycle N+1 (1-cycle latency).
  - While uop_valid_o=1 and uop_ready_in=0, every uop_* output holds stable.
- FSM states:
  - IDLE: uop_valid_o=0.
  - ISSUE: presenting a beat. A beat handshake with !uop_last_o increments uop_beat_o.
  - Last-beat handshake goes to ISSUE if a new instruction is accepted the same cycle, otherwise to IDLE. Back-to-back instructions have no bubble.
- vsetvli (OP_V, funct3=111, instr[31]=0):
  - vsew=instr[25:23], vlmul=instr[22:20].
  - If vsew>3 or vlmul!=000: vill=1, vl=0.
  - Otherwise vill=0, sew=vsew, VLMAX=VLEN/(8<<sew), and vl is set by these rules:
    - rs1 field!=0: vl=min(rs1_data_in, VLMAX), comparison at full DATA_WIDTH.
    - rs1 field==0 and rd!=0: vl=VLMAX.
    - rs1 field==0 and rd==0: vl unchanged, clamped to the new VLMAX.
  - vl/vtype update at the acceptance edge.
  - Emits one beat: uop_is_vset_o=1, uop_vl_o=new vl, last=1.
- OP_V arithmetic (funct3!=111):
  - sew = architectural vsew.
  - uop_valu_op_o from funct6 (instr[31:26]); any other funct6 is illegal:
    - ADD 000000→0
    - SUB 000010→1
    - SLL 100101→2
    - SLT 011011→3
    - SLTU 011010→4
    - XOR 001011→5
    - SRL 101000→6
    - SRA 101001→7
    - OR 001010→8
    - AND 001001→9
- OP_VL / OP_VS:
  - Width from funct3: 000=8, 101=16, 110=32, 111=64; any other funct3 is illegal.
  - vmem_read / vmem_write set on every beat.
- Beat count for vector ops: beats = ceil(vl/NUM_LANES).
- Boundary conditions:
  - vill=1 or illegal encoding: the instruction is accepted, no uop is emitted, and illegal_o pulses in the cycle after acceptance.
  - vl=0 with vill=0: the instruction is accepted and silently dropped; no uop, no illegal_o.
- Scalar opcodes: one beat with uop_is_vector_o=0, beat 0, last=1, uop_instr_o carrying the instruction.
- A reset asserted mid-sequence clears the state; the next accepted instruction starts fresh at beat 0.

Test Plan:
- Reset: rst_n low mid-sequence → uop_valid_o=0 immediately, vtype_vill_o=1, vl_o=0.
- vsetvli e32 (vsew=010), rs1_data_in=100, VLEN=128 → vl_o=4, vset uop with uop_vl_o=4, last=1; then vadd.vv (funct6=000000) → exactly 1 beat, valu_op=0, last=1.
- vsetvli e8, rs1_data_in=13 → vl=13; vadd → 4 beats numbered 0..3, last only on beat 3; hold uop_ready_in=0 for 3 cycles on beat 1 → outputs stable, no skipped beat.
- vadd issued straight after reset (vill=1) → illegal_o one pulse, no uop; vsetvli with vlmul=001 → vill=1, vl=0.
- OP_VL funct3=101 after vl=8 (e16) → 2 beats, sew=01, vmem_read=1; funct3=010 → illegal_o.
- Back-to-back scalar ADD, ADDI with uop_ready_in=1 → one uop per cycle, instr_ready_o stays 1, uop_is_vector_o=0.

Source files
------------

// File: rtl/vector_uop_sequencer.sv
// Vector front-end stage: decodes scalar/vector instructions, tracks vl/vtype,
// and splits vector ops into ceil(vl/NUM_LANES) uop beats on a valid/ready port.
module vector_uop_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned VLEN       = 128,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned VL_W       = $clog2(VLEN / 8) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  instr_valid_in,
    output logic                  instr_ready_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_in,
    output logic                  uop_valid_o,
    input  logic                  uop_ready_in,
    output logic                  uop_is_vector_o,
    output logic                  uop_is_vset_o,
    output logic [DATA_WIDTH-1:0] uop_instr_o,
    output logic [3:0]            uop_valu_op_o,
    output logic                  uop_vmem_read_o,
    output logic                  uop_vmem_write_o,
    output logic [1:0]            uop_sew_o,
    output logic                  uop_mask_en_o,
    output logic [VL_W-1:0]       uop_beat_o,
    output logic                  uop_last_o,
    output logic [VL_W-1:0]       uop_vl_o,
    output logic [VL_W-1:0]       vl_o,
    output logic [1:0]            vtype_sew_o,
    output logic                  vtype_vill_o,
    output logic                  illegal_o
);

    localparam int unsigned LANE_SH  = $clog2(NUM_LANES);
    localparam int unsigned VLMAX_E8 = VLEN / 8;
    localparam logic [6:0]  OP_V     = 7'b1010111;
    localparam logic [6:0]  OP_VL    = 7'b0000111;
    localparam logic [6:0]  OP_VS    = 7'b0100111;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                state_q, state_d;
    logic [VL_W-1:0]       beat_last_q, beat_last_d;
    logic                  is_vector_d, is_vset_d, vmem_read_d, vmem_write_d;
    logic                  mask_en_d, last_d, vill_d, illegal_d;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [3:0]            valu_op_d;
    logic [1:0]            uop_sew_d, vsew_d;
    logic [VL_W-1:0]       beat_d, uop_vl_d, vl_d;

    // instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3, vsew_f, vlmul_f;
    logic [4:0] rs1_f, rd_f;
    logic [5:0] funct6;

    assign opcode  = instr_in[6:0];
    assign rd_f    = instr_in[11:7];
    assign funct3  = instr_in[14:12];
    assign rs1_f   = instr_in[19:15];
    assign vlmul_f = instr_in[22:20];
    assign vsew_f  = instr_in[25:23];
    assign funct6  = instr_in[31:26];

    logic            is_vset, is_vec_op, enc_ok, valu_ok, mem_ok, accept;
    logic [3:0]      valu_code;
    logic [1:0]      mem_sew;
    logic [VL_W-1:0] vlmax, new_vl, vl_last;
    logic            new_vill;
    logic [1:0]      new_sew;

    assign uop_valid_o   = (state_q == S_ISSUE);
    assign instr_ready_o = !uop_valid_o || (uop_ready_in && uop_last_o);
    assign accept        = instr_valid_in && instr_ready_o;

    assign is_vset   = (opcode == OP_V) && (funct3 == 3'b111) && !instr_in[31];
    assign is_vec_op = ((opcode == OP_V) || (opcode == OP_VL) || (opcode == OP_VS)) && !is_vset;
    assign vlmax     = VL_W'(VLMAX_E8) >> vsew_f[1:0];
    assign vl_last   = (vl_o - VL_W'(1)) >> LANE_SH;

    // funct6 to vector ALU op
    always_comb begin
        valu_ok   = 1'b1;
        valu_code = 4'd0;
        case (funct6)
            6'b000000: valu_code = 4'd0;
            6'b000010: valu_code = 4'd1;
            6'b100101: valu_code = 4'd2;
            6'b011011: valu_code = 4'd3;
            6'b011010: valu_code = 4'd4;
            6'b001011: valu_code = 4'd5;
            6'b101000: valu_code = 4'd6;
            6'b101001: valu_code = 4'd7;
            6'b001010: valu_code = 4'd8;
            6'b001001: valu_code = 4'd9;
            default:   valu_ok   = 1'b0;
        endcase
    end

    always_comb begin
        mem_ok  = 1'b1;
        mem_sew = 2'd0;
        case (funct3)
            3'b000:  mem_sew = 2'd0;
            3'b101:  mem_sew = 2'd1;
            3'b110:  mem_sew = 2'd2;
            3'b111:  mem_sew = 2'd3;
            default: mem_ok  = 1'b0;
        endcase
    end

    always_comb begin
        enc_ok = 1'b0;
        if (opcode == OP_V) begin
            enc_ok = (funct3 != 3'b111) && valu_ok;
        end else begin
            enc_ok = mem_ok;
        end
    end

    // vsetvli result: new vtype and vl
    always_comb begin
        new_vill = (vsew_f > 3'd3) || (vlmul_f != 3'd0);
        new_sew  = new_vill ? 2'd0 : vsew_f[1:0];
        new_vl   = '0;
        if (!new_vill) begin
            if (rs1_f != 5'd0) begin
                new_vl = (rs1_data_in < DATA_WIDTH'(vlmax)) ? VL_W'(rs1_data_in) : vlmax;
            end else if (rd_f != 5'd0) begin
                new_vl = vlmax;
            end else begin
                new_vl = (vl_o < vlmax) ? vl_o : vlmax;
            end
        end
    end

    // next state and next registered outputs
    always_comb begin
        logic emit;
        emit         = 1'b0;
        state_d      = state_q;
        beat_last_d  = beat_last_q;
        is_vector_d  = uop_is_vector_o;
        is_vset_d    = uop_is_vset_o;
        instr_d      = uop_instr_o;
        valu_op_d    = uop_valu_op_o;
        vmem_read_d  = uop_vmem_read_o;
        vmem_write_d = uop_vmem_write_o;
        uop_sew_d    = uop_sew_o;
        mask_en_d    = uop_mask_en_o;
        beat_d       = uop_beat_o;
        last_d       = uop_last_o;
        uop_vl_d     = uop_vl_o;
        vl_d         = vl_o;
        vsew_d       = vtype_sew_o;
        vill_d       = vtype_vill_o;
        illegal_d    = 1'b0;

        if (uop_valid_o && uop_ready_in) begin
            if (uop_last_o) begin
                state_d = S_IDLE;
            end else begin
                beat_d = uop_beat_o + VL_W'(1);
                last_d = ((uop_beat_o + VL_W'(1)) == beat_last_q);
            end
        end

        if (accept) begin
            emit         = 1'b1;
            instr_d      = instr_in;
            mask_en_d    = instr_in[25];
            is_vector_d  = 1'b0;
            is_vset_d    = 1'b0;
            valu_op_d    = 4'd0;
            vmem_read_d  = 1'b0;
            vmem_write_d = 1'b0;
            uop_sew_d    = 2'd0;
            uop_vl_d     = vl_o;
            beat_d       = '0;
            last_d       = 1'b1;
            beat_last_d  = '0;
            if (is_vset) begin
                vl_d        = new_vl;
                vsew_d      = new_sew;
                vill_d      = new_vill;
                is_vector_d = 1'b1;
                is_vset_d   = 1'b1;
                uop_sew_d   = new_sew;
                uop_vl_d    = new_vl;
            end else if (is_vec_op) begin
                is_vector_d = 1'b1;
                if (vtype_vill_o || !enc_ok) begin
                    emit      = 1'b0;
                    illegal_d = 1'b1;
                end else if (vl_o == '0) begin
                    emit = 1'b0;
                end else begin
                    valu_op_d    = (opcode == OP_V) ? valu_code : 4'd0;
                    vmem_read_d  = (opcode == OP_VL);
                    vmem_write_d = (opcode == OP_VS);
                    uop_sew_d    = (opcode == OP_V) ? vtype_sew_o : mem_sew;
                    beat_last_d  = vl_last;
                    last_d       = (vl_last == '0);
                end
            end
            state_d = emit ? S_ISSUE : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            beat_last_q      <= '0;
            uop_is_vector_o  <= 1'b0;
            uop_is_vset_o    <= 1'b0;
            uop_instr_o      <= '0;
            uop_valu_op_o    <= 4'd0;
            uop_vmem_read_o  <= 1'b0;
            uop_vmem_write_o <= 1'b0;
            uop_sew_o        <= 2'd0;
            uop_mask_en_o    <= 1'b0;
            uop_beat_o       <= '0;
            uop_last_o       <= 1'b0;
            uop_vl_o         <= '0;
            vl_o             <= '0;
            vtype_sew_o      <= 2'd0;
            vtype_vill_o     <= 1'b1;
            illegal_o        <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_last_q      <= beat_last_d;
            uop_is_vector_o  <= is_vector_d;
            uop_is_vset_o    <= is_vset_d;
            uop_instr_o      <= instr_d;
            uop_valu_op_o    <= valu_op_d;
            uop_vmem_read_o  <= vmem_read_d;
            uop_vmem_write_o <= vmem_write_d;
            uop_sew_o        <= uop_sew_d;
            uop_mask_en_o    <= mask_en_d;
            uop_beat_o       <= beat_d;
            uop_last_o       <= last_d;
            uop_vl_o         <= uop_vl_d;
            vl_o             <= vl_d;
            vtype_sew_o      <= vsew_d;
            vtype_vill_o     <= vill_d;
            illegal_o        <= illegal_d;
        end
    end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Randomized bench for vector_uop_sequencer against a queue-based model of the
// expected uop stream and architectural vl/vtype state.
module tb_vector_uop_sequencer;

    localparam int DW   = 32;
    localparam int VLEN = 128;
    localparam int NL   = 4;
    localparam int VLW  = $clog2(VLEN / 8) + 1;
    localparam logic [6:0] OP_V  = 7'b1010111;
    localparam logic [6:0] OP_VL = 7'b0000111;
    localparam logic [6:0] OP_VS = 7'b0100111;

    logic           clk;
    logic           rst_n;
    logic [DW-1:0]  instr_in, rs1_data_in, uop_instr_o;
    logic           instr_valid_in, instr_ready_o, uop_valid_o, uop_ready_in;
    logic           uop_is_vector_o, uop_is_vset_o, uop_vmem_read_o, uop_vmem_write_o;
    logic [3:0]     uop_valu_op_o;
    logic [1:0]     uop_sew_o, vtype_sew_o;
    logic           uop_mask_en_o, uop_last_o, vtype_vill_o, illegal_o;
    logic [VLW-1:0] uop_beat_o, uop_vl_o, vl_o;

    vector_uop_sequencer #(.DATA_WIDTH(DW), .VLEN(VLEN), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
        .instr_ready_o(instr_ready_o), .rs1_data_in(rs1_data_in), .uop_valid_o(uop_valid_o),
        .uop_ready_in(uop_ready_in), .uop_is_vector_o(uop_is_vector_o),
        .uop_is_vset_o(uop_is_vset_o), .uop_instr_o(uop_instr_o), .uop_valu_op_o(uop_valu_op_o),
        .uop_vmem_read_o(uop_vmem_read_o), .uop_vmem_write_o(uop_vmem_write_o),
        .uop_sew_o(uop_sew_o), .uop_mask_en_o(uop_mask_en_o), .uop_beat_o(uop_beat_o),
        .uop_last_o(uop_last_o), .uop_vl_o(uop_vl_o), .vl_o(vl_o), .vtype_sew_o(vtype_sew_o),
        .vtype_vill_o(vtype_vill_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vec;
        logic        vset;
        logic [31:0] instr;
        int          op;
        logic        rd;
        logic        wr;
        int          sew;
        logic        mask;
        int          beat;
        logic        last;
        int          vl;
    } exp_t;

    exp_t        q[$];
    int          m_vl, m_sew;
    bit          m_vill, m_illegal, acc;
    int unsigned n_vec, n_bad;
    int          hs_cnt, last_cnt;
    int          f6_tab[10] = '{0, 2, 37, 27, 26, 11, 40, 41, 10, 9};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int valu_of(input int f6);
        for (int i = 0; i < 10; i++) if (f6_tab[i] == f6) return i;
        return -1;
    endfunction

    function automatic int memw_of(input int f3);
        if (f3 == 0) return 0;
        if (f3 == 5) return 1;
        if (f3 == 6) return 2;
        if (f3 == 7) return 3;
        return -1;
    endfunction

    // expected effect of one accepted instruction
    task automatic model_accept(input logic [31:0] ins, input logic [31:0] d);
        exp_t e;
        int op, f3, vsew, vlmul, vlmax, code, beats;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        e.vec = 1'b0; e.vset = 1'b0; e.instr = ins; e.op = 0; e.rd = 1'b0; e.wr = 1'b0;
        e.sew = 0; e.mask = ins[25]; e.beat = 0; e.last = 1'b1; e.vl = m_vl;
        if (op == int'(OP_V) && f3 == 7 && !ins[31]) begin
            vsew  = int'(ins[25:23]);
            vlmul = int'(ins[22:20]);
            if (vsew > 3 || vlmul != 0) begin
                m_vill = 1'b1; m_vl = 0; m_sew = 0;
            end else begin
                m_vill = 1'b0; m_sew = vsew;
                vlmax = VLEN / (8 << vsew);
                if (ins[19:15] != 0)     m_vl = (longint'(d) < vlmax) ? int'(d) : vlmax;
                else if (ins[11:7] != 0) m_vl = vlmax;
                else if (m_vl > vlmax)   m_vl = vlmax;
            end
            e.vec = 1'b1; e.vset = 1'b1; e.sew = m_sew; e.vl = m_vl;
            q.push_back(e);
        end else if (op == int'(OP_V) || op == int'(OP_VL) || op == int'(OP_VS)) begin
            if (op == int'(OP_V)) code = (f3 == 7) ? -1 : valu_of(int'(ins[31:26]));
            else                  code = memw_of(f3);
            if (m_vill || code < 0) begin
                m_illegal = 1'b1;
            end else if (m_vl != 0) begin
                e.vec = 1'b1;
                e.op  = (op == int'(OP_V)) ? code : 0;
                e.sew = (op == int'(OP_V)) ? m_sew : code;
                e.rd  = (op == int'(OP_VL));
                e.wr  = (op == int'(OP_VS));
                beats = (m_vl + NL - 1) / NL;
                for (int i = 0; i < beats; i++) begin
                    e.beat = i;
                    e.last = (i == beats - 1);
                    q.push_back(e);
                end
            end
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic compare();
        exp_t e;
        chk("uop_valid", uop_valid_o, q.size() != 0);
        chk("instr_ready", instr_ready_o, (q.size() == 0) || (q.size() == 1 && uop_ready_in));
        chk("illegal", illegal_o, m_illegal);
        chk("vl", vl_o, m_vl);
        chk("vtype_sew", vtype_sew_o, m_sew);
        chk("vtype_vill", vtype_vill_o, m_vill);
        if (q.size() != 0 && uop_valid_o) begin
            e = q[0];
            chk("is_vector", uop_is_vector_o, e.vec);
            chk("is_vset", uop_is_vset_o, e.vset);
            chk("instr", uop_instr_o, e.instr);
            chk("valu_op", uop_valu_op_o, e.op);
            chk("vmem_read", uop_vmem_read_o, e.rd);
            chk("vmem_write", uop_vmem_write_o, e.wr);
            chk("uop_sew", uop_sew_o, e.sew);
            chk("mask_en", uop_mask_en_o, e.mask);
            chk("beat", uop_beat_o, e.beat);
            chk("last", uop_last_o, e.last);
            chk("uop_vl", uop_vl_o, e.vl);
        end
    endtask

    // one clock: inputs are final here, model advances at the edge, check at negedge
    task automatic step();
        if (uop_valid_o && uop_ready_in) begin
            hs_cnt++;
            if (uop_last_o) last_cnt++;
        end
        @(posedge clk);
        acc = instr_valid_in && (q.size() == 0 || (q.size() == 1 && uop_ready_in));
        if (q.size() != 0 && uop_ready_in) void'(q.pop_front());
        m_illegal = 1'b0;
        if (acc) model_accept(instr_in, rs1_data_in);
        @(negedge clk);
        compare();
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] d);
        int guard;
        guard = 0;
        instr_in = ins; rs1_data_in = d; instr_valid_in = 1'b1;
        do begin
            step();
            guard++;
        end while (!acc && guard < 50);
        chk("accept_in_time", acc, 1'b1);
        instr_valid_in = 1'b0;
    endtask

    task automatic drain(input int n);
        instr_valid_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_vl = 0; m_sew = 0; m_vill = 1'b1; m_illegal = 1'b0;
        chk("rst_mid_valid", uop_valid_o, 1'b0);
        chk("rst_mid_vill", vtype_vill_o, 1'b1);
        chk("rst_mid_vl", vl_o, 0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] mk_vset(input int vsew, input int vlmul, input int rs1f, input int rdf);
        logic [31:0] w;
        w = '0;
        w[6:0] = OP_V; w[11:7] = 5'(rdf); w[14:12] = 3'b111; w[19:15] = 5'(rs1f);
        w[22:20] = 3'(vlmul); w[25:23] = 3'(vsew);
        return w;
    endfunction

    function automatic logic [31:0] mk_varith(input int f6, input logic vm, input int f3);
        logic [31:0] w;
        w = '0;
        w[31:26] = 6'(f6); w[25] = vm; w[24:20] = 5'd2; w[19:15] = 5'd3;
        w[14:12] = 3'(f3); w[11:7] = 5'd1; w[6:0] = OP_V;
        return w;
    endfunction

    function automatic logic [31:0] mk_vmem(input logic [6:0] opc, input int f3, input logic vm);
        logic [31:0] w;
        w = '0;
        w[6:0] = opc; w[11:7] = 5'd4; w[14:12] = 3'(f3); w[19:15] = 5'd10; w[25] = vm;
        return w;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int k;
        k = $urandom_range(0, 9);
        if (k < 2) begin
            w = mk_vset(($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0,
                        $urandom_range(0, 2), $urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) w[31] = 1'b1;
        end else if (k < 6) begin
            w = mk_varith(($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)
                                                      : f6_tab[$urandom_range(0, 9)],
                          1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end else if (k < 8) begin
            w = mk_vmem(($urandom_range(0, 1) == 0) ? OP_VL : OP_VS, $urandom_range(0, 7),
                        1'($urandom_range(0, 1)));
        end else begin
            w = $urandom();
            w[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
        end
        return w;
    endfunction

    initial begin
        n_vec = 0; n_bad = 0; hs_cnt = 0; last_cnt = 0;
        m_vl = 0; m_sew = 0; m_vill = 1'b1; m_illegal = 1'b0; acc = 1'b0;
        rst_n = 1'b0; instr_in = '0; rs1_data_in = '0; instr_valid_in = 1'b0; uop_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_vill", vtype_vill_o, 1'b1);
        chk("reset_valid", uop_valid_o, 1'b0);
        compare();
        rst_n = 1'b1;

        // vector op straight after reset: vill=1 -> illegal pulse, no uop
        issue(mk_varith(0, 1'b1, 0), 0);
        chk("illegal_pulse", illegal_o, 1'b1);
        step();
        chk("illegal_one_cycle", illegal_o, 1'b0);

        // e32, AVL 100 -> vl 4; vadd -> one beat
        issue(mk_vset(2, 0, 1, 1), 100);
        chk("e32_vl", vl_o, 4);
        chk("e32_vset_uop", uop_is_vset_o, 1'b1);
        chk("e32_uop_vl", uop_vl_o, 4);
        issue(mk_varith(0, 1'b1, 0), 0);
        chk("e32_vadd_last", uop_last_o, 1'b1);
        chk("e32_vadd_op", uop_valu_op_o, 0);
        drain(2);

        // e8, AVL 13 -> 4 beats with a 3-cycle stall on beat 1
        issue(mk_vset(0, 0, 1, 1), 13);
        chk("e8_vl", vl_o, 13);
        drain(1);
        hs_cnt = 0; last_cnt = 0;
        issue(mk_varith(0, 1'b0, 0), 0);
        step();
        uop_ready_in = 1'b0;
        repeat (3) step();
        chk("stall_beat", uop_beat_o, 1);
        uop_ready_in = 1'b1;
        drain(4);
        chk("e8_beats", hs_cnt, 4);
        chk("e8_last_count", last_cnt, 1);

        // vlmul=001 -> vill
        issue(mk_vset(2, 1, 1, 1), 10);
        chk("vlmul_vill", vtype_vill_o, 1'b1);
        chk("vlmul_vl", vl_o, 0);
        drain(1);

        // e16 vl=8: unit-stride 16-bit load -> 2 beats; bad width -> illegal
        issue(mk_vset(1, 0, 1, 1), 8);
        chk("e16_vl", vl_o, 8);
        issue(mk_vmem(OP_VL, 5, 1'b1), 0);
        chk("vle16_sew", uop_sew_o, 1);
        chk("vle16_read", uop_vmem_read_o, 1'b1);
        drain(3);
        issue(mk_vmem(OP_VL, 2, 1'b1), 0);
        chk("vl_bad_width", illegal_o, 1'b1);
        drain(1);

        // back-to-back scalar ADD, ADDI
        issue(32'h003100B3, 0);
        issue(32'h00508093, 0);
        chk("addi_scalar", uop_is_vector_o, 1'b0);
        chk("addi_instr", uop_instr_o, 32'h00508093);
        drain(2);

        // reset in the middle of a 4-beat sequence
        issue(mk_vset(0, 0, 1, 1), 16);
        issue(mk_varith(11, 1'b1, 0), 0);
        uop_ready_in = 1'b0;
        step();
        async_reset();
        uop_ready_in = 1'b1;
        step();
        issue(mk_vset(0, 0, 0, 1), 0);
        chk("post_rst_vlmax", vl_o, 16);
        issue(mk_varith(2, 1'b1, 0), 0);
        chk("post_rst_beat0", uop_beat_o, 0);
        drain(5);

        for (int i = 0; i < 4000; i++) begin
            instr_valid_in = ($urandom_range(0, 9) < 7);
            instr_in       = rnd_instr();
            rs1_data_in    = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 20));
            uop_ready_in   = ($urandom_range(0, 3) != 0);
            step();
            if (i == 2000) async_reset();
        end
        uop_ready_in = 1'b1;
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
